// File: rtl/axi4_slv_pkg.sv
// rtl/axi4_slv_pkg.sv - response/burst codes and FSM state types for the AXI4 burst slave memory
package axi4_slv_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/axi4_burst_slave_mem_if.sv
// rtl/axi4_burst_slave_mem_if.sv - AXI4 full bus bundle with master/slave modports
interface axi4_burst_slave_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 1
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4_slv_addr_gen.sv
// rtl/axi4_slv_addr_gen.sv - next beat address for FIXED/INCR bursts (WRAP behaves as INCR)
module axi4_slv_addr_gen
  import axi4_slv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            burst,
  input  logic [7:0]            beat_bytes,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  always_comb begin
    next_addr = addr;
    if (burst != BURST_FIXED) begin
      next_addr = addr + ADDR_WIDTH'(beat_bytes);
    end
  end

endmodule

// File: rtl/axi4_burst_slave_mem.sv
// rtl/axi4_burst_slave_mem.sv - AXI4 burst slave over word memory; AXI_RANGE_CHECK_EN adds out-of-range SLVERR
module axi4_burst_slave_mem
  import axi4_slv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int MEM_DEPTH  = 1024
) (
  input logic                   ACLK,
  input logic                   ARESETN,
  axi4_burst_slave_mem_if.slave s_axi
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int IDX_LSB = $clog2(BYTES);
  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam logic [7:0] BEAT_BYTES = 8'(BYTES);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * BYTES);
`ifdef AXI_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // write channel state
  w_state_e              w_state, w_state_n;
  logic [ADDR_WIDTH-1:0] w_addr, w_addr_n, w_addr_inc;
  logic [7:0]            w_len, w_len_n, w_cnt, w_cnt_n;
  logic [1:0]            w_burst, w_burst_n;
  logic                  w_err, w_err_n;
  logic                  awready, awready_n, wready, wready_n, bvalid, bvalid_n;
  logic [1:0]            bresp, bresp_n;
  logic [ID_WIDTH-1:0]   bid, bid_n;
  logic                  w_beat, w_oob;
  logic [IDX_W-1:0]      w_idx;

  // read channel state
  r_state_e              r_state, r_state_n;
  logic [ADDR_WIDTH-1:0] r_addr, r_addr_n, r_addr_inc, r_sel_addr;
  logic [1:0]            r_burst, r_burst_n, r_sel_burst;
  logic [7:0]            r_len, r_len_n, r_cnt, r_cnt_n;
  logic                  arready, arready_n, rvalid, rvalid_n, rlast, rlast_n;
  logic [1:0]            rresp, rresp_n;
  logic [ID_WIDTH-1:0]   rid, rid_n;
  logic [DATA_WIDTH-1:0] rdata, rdata_n, r_word;
  logic                  r_load, r_oob;

  logic unused_ok;
  assign unused_ok = ^{s_axi.awsize, s_axi.arsize};

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bresp   = bresp;
  assign s_axi.bid     = bid;
  assign s_axi.arready = arready;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rlast   = rlast;
  assign s_axi.rresp   = rresp;
  assign s_axi.rdata   = rdata;
  assign s_axi.rid     = rid;

  assign w_beat = s_axi.wvalid && wready;
  assign w_idx  = w_addr[IDX_LSB +: IDX_W];
  assign w_oob  = RANGE_CHECK && ({1'b0, w_addr} >= MEM_BYTES);

  axi4_slv_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_w_addr_gen (
    .addr       (w_addr),
    .burst      (w_burst),
    .beat_bytes (BEAT_BYTES),
    .next_addr  (w_addr_inc)
  );

  always_comb begin
    w_state_n = w_state;
    w_addr_n  = w_addr;
    w_len_n   = w_len;
    w_burst_n = w_burst;
    w_cnt_n   = w_cnt;
    w_err_n   = w_err;
    awready_n = awready;
    wready_n  = wready;
    bvalid_n  = bvalid;
    bresp_n   = bresp;
    bid_n     = bid;
    case (w_state)
      W_IDLE: begin
        awready_n = 1'b1;
        if (s_axi.awvalid && awready) begin
          bid_n     = s_axi.awid;
          w_addr_n  = s_axi.awaddr;
          w_len_n   = s_axi.awlen;
          w_burst_n = s_axi.awburst;
          w_cnt_n   = 8'd0;
          w_err_n   = 1'b0;
          awready_n = 1'b0;
          wready_n  = 1'b1;
          w_state_n = W_DATA;
        end
      end
      W_DATA: begin
        if (w_beat) begin
          w_addr_n = w_addr_inc;
          w_cnt_n  = w_cnt + 8'd1;
          // WLAST must coincide exactly with beat AWLEN; extra beats are still absorbed
          if ((s_axi.wlast != (w_cnt == w_len)) || w_oob) begin
            w_err_n = 1'b1;
          end
          if (s_axi.wlast) begin
            wready_n  = 1'b0;
            bvalid_n  = 1'b1;
            bresp_n   = w_err_n ? RESP_SLVERR : RESP_OKAY;
            w_state_n = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          bvalid_n  = 1'b0;
          awready_n = 1'b1;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      bid     <= '0;
    end else begin
      w_state <= w_state_n;
      w_addr  <= w_addr_n;
      w_len   <= w_len_n;
      w_burst <= w_burst_n;
      w_cnt   <= w_cnt_n;
      w_err   <= w_err_n;
      awready <= awready_n;
      wready  <= wready_n;
      bvalid  <= bvalid_n;
      bresp   <= bresp_n;
      bid     <= bid_n;
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_beat && !w_oob) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_axi.wstrb[b]) begin
          mem[w_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
        end
      end
    end
  end

  // beat 0 is addressed straight from ARADDR so it can be presented the cycle after AR
  assign r_sel_addr  = (r_state == R_IDLE) ? s_axi.araddr  : r_addr;
  assign r_sel_burst = (r_state == R_IDLE) ? s_axi.arburst : r_burst;
  assign r_word      = mem[r_sel_addr[IDX_LSB +: IDX_W]];
  assign r_oob       = RANGE_CHECK && ({1'b0, r_sel_addr} >= MEM_BYTES);

  axi4_slv_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_r_addr_gen (
    .addr       (r_sel_addr),
    .burst      (r_sel_burst),
    .beat_bytes (BEAT_BYTES),
    .next_addr  (r_addr_inc)
  );

  always_comb begin
    r_state_n = r_state;
    r_addr_n  = r_addr;
    r_burst_n = r_burst;
    r_len_n   = r_len;
    r_cnt_n   = r_cnt;
    arready_n = arready;
    rvalid_n  = rvalid;
    rlast_n   = rlast;
    rresp_n   = rresp;
    rid_n     = rid;
    rdata_n   = rdata;
    r_load    = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready_n = 1'b1;
        if (s_axi.arvalid && arready) begin
          rid_n     = s_axi.arid;
          r_len_n   = s_axi.arlen;
          r_burst_n = s_axi.arburst;
          r_cnt_n   = 8'd0;
          arready_n = 1'b0;
          r_load    = 1'b1;
          r_state_n = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid && s_axi.rready) begin
          if (rlast) begin
            rvalid_n  = 1'b0;
            rlast_n   = 1'b0;
            arready_n = 1'b1;
            r_state_n = R_IDLE;
          end else begin
            r_cnt_n = r_cnt + 8'd1;
            r_load  = 1'b1;
          end
        end
      end
      default: r_state_n = R_IDLE;
    endcase
    if (r_load) begin
      rvalid_n = 1'b1;
      rdata_n  = r_oob ? '0 : r_word;
      rresp_n  = r_oob ? RESP_SLVERR : RESP_OKAY;
      rlast_n  = (r_cnt_n == r_len_n);
      r_addr_n = r_addr_inc;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_burst <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rid     <= '0;
      rdata   <= '0;
    end else begin
      r_state <= r_state_n;
      r_addr  <= r_addr_n;
      r_burst <= r_burst_n;
      r_len   <= r_len_n;
      r_cnt   <= r_cnt_n;
      arready <= arready_n;
      rvalid  <= rvalid_n;
      rlast   <= rlast_n;
      rresp   <= rresp_n;
      rid     <= rid_n;
      rdata   <= rdata_n;
    end
  end

endmodule

// File: doc/axi4_burst_slave_mem.md
Name: axi4_burst_slave_mem

Overview:
AXI4-full memory-mapped slave that responds to bursts issued by the SA AXI4 master IP: the responder end of the same M00_AXI interface. It holds word-addressed on-chip memory and has independent write (AW/W/B) and read (AR/R) channel state machines. It sits as the target of the master in the block design, either as a synthesizable scratch memory or as an RTL stand-in for the slave VIP.

Parameters:
DATA_WIDTH, 32, AXI data width in bits (32 or 64)
ADDR_WIDTH, 32, AXI address width
ID_WIDTH, 1, AXI ID width
MEM_DEPTH, 1024, memory depth in DATA_WIDTH words (power of two)

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWID / AWADDR / AWLEN / AWSIZE / AWBURST  in  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  write address
S_AXI_AWVALID in 1; S_AXI_AWREADY out 1  AW handshake
S_AXI_WDATA / WSTRB / WLAST  in  DATA_WIDTH / DATA_WIDTH/8 / 1  write data
S_AXI_WVALID in 1; S_AXI_WREADY out 1  W handshake
S_AXI_BID / BRESP  out  ID_WIDTH / 2  write response
S_AXI_BVALID out 1; S_AXI_BREADY in 1  B handshake
S_AXI_ARID / ARADDR / ARLEN / ARSIZE / ARBURST  in  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  read address
S_AXI_ARVALID in 1; S_AXI_ARREADY out 1  AR handshake
S_AXI_RID / RDATA / RRESP / RLAST  out  ID_WIDTH / DATA_WIDTH / 2 / 1  read data
S_AXI_RVALID out 1; S_AXI_RREADY in 1  R handshake

Behaviour:
- Reset: all outputs 0 (AWREADY, WREADY, BVALID, BRESP, BID, ARREADY, RVALID, RLAST, RRESP, RDATA, RID). Both FSMs go to IDLE. Memory contents are not cleared.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - AWREADY is registered. It goes high on the first ACLK edge after ARESETN deasserts and stays high in W_IDLE.
  - AW handshake: capture ID, address, AWLEN and burst; clear the beat counter; drop AWREADY; assert WREADY the next cycle.
  - W_DATA: each WVALID&&WREADY beat writes the memory byte lanes enabled by WSTRB, at index = addr[log2(MEM_DEPTH)+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)].
  - Address update: INCR advances by DATA_WIDTH/8; FIXED holds; WRAP is treated as INCR. The index wraps modulo MEM_DEPTH.
  - Throughput: one beat per cycle.
  - A beat with WLAST=1 ends W_DATA: WREADY drops, then BVALID=1 with BID = captured ID.
  - BRESP=OKAY (00), unless WLAST arrived on a beat other than beat AWLEN, or beat AWLEN arrived without WLAST. In either case BRESP=SLVERR (10) and beats continue to be accepted until WLAST.
  - W_RESP: BVALID holds until BREADY. On the handshake, return to W_IDLE and raise AWREADY the next cycle.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - ARREADY is registered and high in R_IDLE.
  - AR handshake: capture ID, address, ARLEN and burst; drop ARREADY.
  - Latency: RVALID with beat 0 one cycle after the AR handshake.
  - RDATA is registered. On RVALID&&RREADY the next beat is presented the following cycle, giving one beat per cycle under continuous RREADY.
  - RVALID/RDATA/RLAST hold stable while RREADY=0.
  - RLAST=1 on beat ARLEN. The handshake on that beat returns to R_IDLE.
  - RRESP=OKAY.
- Channels are fully independent. A read and a write to the same word in the same cycle return the old data (read-before-write).
- Only one outstanding transaction per direction. AWSIZE/ARSIZE are assumed full-width and are ignored.
- Reset asserted mid-burst aborts the burst immediately. Memory beats already written remain.

Optional Feature:
AXI_RANGE_CHECK_EN
- Defined: any beat whose byte address is >= MEM_DEPTH*DATA_WIDTH/8 is not written, and forces BRESP=SLVERR for that burst. An out-of-range read beat returns RDATA=0 with RRESP=SLVERR for that beat only.
- Not defined: addresses wrap modulo the memory size, and RRESP is always OKAY.

Decomposition:
- Package axi4_slv_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10; BURST_FIXED/INCR/WRAP codes; the write and read FSM state enums.
- Sub-module axi4_slv_addr_gen: combinational next-address calculation from (addr, burst, bytes-per-beat). It is instantiated once per channel.

Test Plan:
- INCR write, AWADDR=0x40, AWLEN=3, data 0x11..0x44, WSTRB=0xF, BREADY=1 -> one BVALID with BRESP=00. A subsequent read of the same burst returns 0x11,0x22,0x33,0x44 with RLAST on beat 3.
- Partial strobe: word 0x0 = 0xAABBCCDD, then write 0x11223344 with WSTRB=0x3 -> reads back 0xAABB3344.
- Backpressure: 8-beat read with RREADY toggling every other cycle -> RDATA stable while stalled, all 8 beats in order, no beat dropped.
- WLAST early: AWLEN=3, WLAST on beat 1 -> BRESP=10, FSM returns to W_IDLE, next AW accepted.
- Wrap and reset: write at byte 0xFFC with MEM_DEPTH=1024, AWLEN=1 -> second beat lands at word 0. Asserting ARESETN low mid read burst -> RVALID=0 immediately, ARREADY=1 after release.
- With AXI_RANGE_CHECK_EN, read at 0x1000 -> RDATA=0, RRESP=10.
